// File: rtl/alu_seq.sv
// Sequential 16-bit ALU: single-cycle logic/add/sub, 16-cycle shift-add multiply
// and (when ALU_SEQ_DIV_EN is defined) 16-cycle restoring divide.
module alu_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [2:0]  OP,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] Y,
    output logic        BUSY,
    output logic        DONE,
    output logic        ZERO,
    output logic        CARRY,
    output logic        OVF,
    output logic        DIVZ
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] FIN  = 2'b10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [2:0] OP_DIV = 3'b110;
`endif

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_y;
    logic        r_busy;
    logic        r_done;
    logic        r_zero;
    logic        r_carry;
    logic        r_ovf;
    logic        r_divz;

    logic [31:0] r_mul_mc;
    logic [15:0] r_mul_mr;
    logic [31:0] r_mul_acc;
    logic [31:0] w_mul_acc_nxt;

`ifdef ALU_SEQ_DIV_EN
    logic        r_is_div;
    logic [15:0] r_div_b;
    logic [15:0] r_div_rem;
    logic [15:0] r_div_quo;
    logic [16:0] w_div_shift;
    logic [16:0] w_div_diff;
    logic        w_div_ge;
    logic [15:0] w_div_rem_nxt;
    logic [15:0] w_div_quo_nxt;
`endif

    logic        w_accept;
    logic        w_last;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [31:0] w_sc_y;
    logic        w_sc_carry;
    logic        w_sc_ovf;
    logic        w_sc_divz;
    logic        w_sc_multi;
    logic [31:0] w_calc_y;

    assign w_accept = START && (r_state != CALC);
    assign w_last   = (r_cnt == 5'd15);
    assign w_sum    = {1'b0, A} + {1'b0, B};
    assign w_diff   = {1'b0, A} - {1'b0, B};

    assign w_mul_acc_nxt = r_mul_mr[0] ? (r_mul_acc + r_mul_mc) : r_mul_acc;

`ifdef ALU_SEQ_DIV_EN
    // Restoring step: the partial remainder never exceeds 2*B-1, so bit 16 of the difference is the sign.
    assign w_div_shift   = {r_div_rem, r_div_quo[15]};
    assign w_div_diff    = w_div_shift - {1'b0, r_div_b};
    assign w_div_ge      = ~w_div_diff[16];
    assign w_div_rem_nxt = w_div_ge ? w_div_diff[15:0] : w_div_shift[15:0];
    assign w_div_quo_nxt = {r_div_quo[14:0], w_div_ge};
    assign w_calc_y      = r_is_div ? {w_div_rem_nxt, w_div_quo_nxt} : w_mul_acc_nxt;
`else
    assign w_calc_y      = w_mul_acc_nxt;
`endif

    // Single-cycle result and flags, computed from the operands present at acceptance.
    always_comb begin
        w_sc_y     = 32'h0000_0000;
        w_sc_carry = 1'b0;
        w_sc_ovf   = 1'b0;
        w_sc_divz  = 1'b0;
        w_sc_multi = 1'b0;
        case (OP)
            OP_ADD: begin
                w_sc_y     = {16'h0000, w_sum[15:0]};
                w_sc_carry = w_sum[16];
                w_sc_ovf   = (A[15] == B[15]) && (w_sum[15] != A[15]);
            end
            OP_SUB: begin
                w_sc_y     = {16'h0000, w_diff[15:0]};
                w_sc_carry = w_diff[16];
                w_sc_ovf   = (A[15] != B[15]) && (w_diff[15] != A[15]);
            end
            OP_AND: w_sc_y = {16'h0000, A & B};
            OP_OR:  w_sc_y = {16'h0000, A | B};
            OP_XOR: w_sc_y = {16'h0000, A ^ B};
            OP_MUL: w_sc_multi = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                if (B == 16'h0000) begin
                    w_sc_y    = {A, 16'hFFFF};
                    w_sc_divz = 1'b1;
                end else begin
                    w_sc_multi = 1'b1;
                end
            end
`endif
            default: w_sc_y = 32'h0000_0000;
        endcase
    end

    // Control FSM next state; START is honoured from IDLE and FIN only.
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE, FIN: begin
                if (w_accept) begin
                    w_state_nxt = w_sc_multi ? CALC : FIN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, datapath iteration and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_y       <= 32'h0000_0000;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_divz    <= 1'b0;
            r_mul_mc  <= 32'h0000_0000;
            r_mul_mr  <= 16'h0000;
            r_mul_acc <= 32'h0000_0000;
`ifdef ALU_SEQ_DIV_EN
            r_is_div  <= 1'b0;
            r_div_b   <= 16'h0000;
            r_div_rem <= 16'h0000;
            r_div_quo <= 16'h0000;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == CALC);
            r_done  <= (w_state_nxt == FIN);
            if (w_accept) begin
                r_cnt     <= 5'd0;
                r_mul_mc  <= {16'h0000, A};
                r_mul_mr  <= B;
                r_mul_acc <= 32'h0000_0000;
`ifdef ALU_SEQ_DIV_EN
                r_is_div  <= (OP == OP_DIV);
                r_div_b   <= B;
                r_div_rem <= 16'h0000;
                r_div_quo <= A;
`endif
                if (!w_sc_multi) begin
                    r_y     <= w_sc_y;
                    r_zero  <= (w_sc_y == 32'h0000_0000);
                    r_carry <= w_sc_carry;
                    r_ovf   <= w_sc_ovf;
                    r_divz  <= w_sc_divz;
                end
            end else if (r_state == CALC) begin
                r_cnt     <= w_last ? r_cnt : (r_cnt + 5'd1);
                r_mul_acc <= w_mul_acc_nxt;
                r_mul_mc  <= {r_mul_mc[30:0], 1'b0};
                r_mul_mr  <= {1'b0, r_mul_mr[15:1]};
`ifdef ALU_SEQ_DIV_EN
                r_div_rem <= w_div_rem_nxt;
                r_div_quo <= w_div_quo_nxt;
`endif
                if (w_last) begin
                    r_y     <= w_calc_y;
                    r_zero  <= (w_calc_y == 32'h0000_0000);
                    r_carry <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_divz  <= 1'b0;
                end
            end
        end
    end

    assign Y     = r_y;
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign ZERO  = r_zero;
    assign CARRY = r_carry;
    assign OVF   = r_ovf;
    assign DIVZ  = r_divz;

endmodule
